// File: rtl/core_bus_arbiter_if.sv
// Bundle of the core fetch/data ports and the single memory channel seen by core_bus_arbiter.
// The slave modport is the arbiter's view; master is the core-plus-memory environment.
interface core_bus_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              iresp_addr_ok;
    logic              iresp_data_ok;
    logic [31:0]       iresp_data;

    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [2:0]        dreq_size;
    logic [7:0]        dreq_strobe;
    logic [63:0]       dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [63:0]       dresp_data;

    logic              mreq_valid;
    logic              mreq_write;
    logic [ADDR_W-1:0] mreq_addr;
    logic [2:0]        mreq_size;
    logic [7:0]        mreq_strobe;
    logic [63:0]       mreq_data;
    logic              mreq_ready;
    logic              mresp_valid;
    logic [63:0]       mresp_data;

    modport slave (
        input  ireq_valid, ireq_addr,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  mreq_ready, mresp_valid, mresp_data,
        output iresp_addr_ok, iresp_data_ok, iresp_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        output mreq_valid, mreq_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
    );

    modport master (
        output ireq_valid, ireq_addr,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output mreq_ready, mresp_valid, mresp_data,
        input  iresp_addr_ok, iresp_data_ok, iresp_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        input  mreq_valid, mreq_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// Arbitrates core fetch and data masters onto one single-outstanding memory channel.
// Data wins ties, but after MAX_D_STREAK data grants with a fetch waiting, fetch goes next.
module core_bus_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int ADDR_W       = 64
) (
    input  logic                clk,
    input  logic                reset,
    core_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam int              STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [2:0]      SIZE_4B    = 3'd2;

    state_t              state_q, state_d;
    logic                src_d_q, src_d_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [7:0]          strobe_q, strobe_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [63:0]         rdata_q, rdata_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic grant_d;
    logic grant_i;

    assign grant_d = bus.dreq_valid && (!bus.ireq_valid || (streak_q < STREAK_MAX));
    assign grant_i = !grant_d && bus.ireq_valid;

    always_comb begin
        state_d  = state_q;
        src_d_d  = src_d_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    src_d_d  = 1'b1;
                    addr_d   = bus.dreq_addr;
                    size_d   = bus.dreq_size;
                    strobe_d = bus.dreq_strobe;
                    wdata_d  = bus.dreq_data;
                    state_d  = REQ;
                    // The streak only matters while fetch is actually waiting.
                    if (bus.ireq_valid) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_i) begin
                    src_d_d  = 1'b0;
                    addr_d   = bus.ireq_addr;
                    size_d   = SIZE_4B;
                    strobe_d = 8'h00;
                    wdata_d  = 64'h0;
                    streak_d = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.mreq_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mresp_valid) begin
                    rdata_d = bus.mresp_data;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            src_d_q  <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            src_d_q  <= src_d_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            streak_q <= streak_d;
        end
    end

    // The memory channel is fed purely from the latched copy, so masters may change inputs freely.
    assign bus.mreq_valid  = (state_q == REQ);
    assign bus.mreq_write  = |strobe_q;
    assign bus.mreq_addr   = addr_q;
    assign bus.mreq_size   = size_q;
    assign bus.mreq_strobe = strobe_q;
    assign bus.mreq_data   = wdata_q;

    assign bus.iresp_addr_ok = (state_q == REQ) && bus.mreq_ready && !src_d_q;
    assign bus.dresp_addr_ok = (state_q == REQ) && bus.mreq_ready &&  src_d_q;
    assign bus.iresp_data_ok = (state_q == DONE) && !src_d_q;
    assign bus.dresp_data_ok = (state_q == DONE) &&  src_d_q;

    assign bus.iresp_data = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
    assign bus.dresp_data = rdata_q;
endmodule
